// File: rtl/timer_counter_pkg.sv
// Shared defaults and FSM state encoding for the Morse pulse-duration recorder.
package timer_counter_pkg;

   localparam int WID_DEF     = 32;
   localparam int NSLOT_DEF   = 5;
   localparam int END_GAP_DEF = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/reg_n.sv
// N-bit register with write enable and synchronous active-high reset.
module reg_n #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Load d when enabled; reset clears to zero.
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/timer_counter.sv
// Pulse-duration recorder: measures each high pulse of a synchronous key
// level, stores up to NSLOT durations, and flags end-of-message after a
// low gap longer than END_GAP cycles.
//
// Handshake: there is no valid/ready pair. m_end is a sticky completion
// flag; valid qualifies it (1..NSLOT pulses captured). Both are registered,
// rise together and hold until reset. dbg_state mirrors the FSM state.
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int WID     = WID_DEF,
   parameter int NSLOT   = NSLOT_DEF,
   parameter int END_GAP = END_GAP_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sig_in,
   output logic [NSLOT*WID-1:0] value,
   output logic [2:0]           npulse,
   output logic                 m_end,
   output logic                 valid,
   output logic [1:0]           dbg_state
);

   localparam logic [2:0]     NSLOT_N = 3'(NSLOT);
   localparam logic [2:0]     NMAX_N  = 3'(NSLOT + 1);
   localparam logic [WID-1:0] ONE     = WID'(1);
   localparam logic [WID-1:0] GAP_END = WID'(END_GAP + 1);

   state_t         state;
   logic [WID-1:0] cnt;
   logic           s_q;
   logic           s_prev;
   logic           rise;
   logic           fall;
   logic [WID-1:0] cnt_inc;
   logic           gap_hit;
   logic           store;

   // Single input sample stage; the key level is already synchronous.
   reg_n #(.N(1)) u_sample (
      .clk   (clk),
      .reset (reset),
      .we    (1'b1),
      .d     (sig_in),
      .q     (s_q)
   );

   assign rise    = s_q & ~s_prev;
   assign fall    = ~s_q & s_prev;
   // Counter saturates at all ones so a stuck-high key never wraps.
   assign cnt_inc = (&cnt) ? cnt : cnt + ONE;
   // Threshold fires on the edge where the low count would pass END_GAP.
   assign gap_hit = (cnt_inc == GAP_END);
   assign store   = (state == ST_HIGH) && fall && (npulse < NSLOT_N);

   // Capture bank: slot npulse takes the counter on the falling edge.
   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      reg_n #(.N(WID)) u_slot (
         .clk   (clk),
         .reset (reset),
         .we    (store && (npulse == 3'(i))),
         .d     (cnt),
         .q     (value[WID*i +: WID])
      );
   end

   // Measurement FSM with inline duration counter and registered flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         npulse <= '0;
         m_end  <= 1'b0;
         valid  <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         s_prev <= s_q;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (rise) begin
                  state <= ST_HIGH;
                  cnt   <= ONE;
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  npulse <= (npulse == NMAX_N) ? npulse : npulse + 3'd1;
                  cnt    <= ONE;
                  state  <= ST_GAP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_GAP: begin
               // A rise in the threshold cycle still starts a new pulse.
               if (rise) begin
                  cnt   <= ONE;
                  state <= ST_HIGH;
               end else if (gap_hit) begin
                  cnt   <= cnt_inc;
                  state <= ST_DONE;
                  m_end <= 1'b1;
                  valid <= (npulse >= 3'd1) && (npulse <= NSLOT_N);
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               // Message complete: everything frozen until reset.
               state <= ST_DONE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random
// pulse trains scored against a segment-level behavioural model.
module tb_timer_counter;
   import timer_counter_pkg::*;

   localparam int WID     = 32;
   localparam int NSLOT   = 5;
   localparam int END_GAP = 30;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 sig_in;
   logic [NSLOT*WID-1:0] value;
   logic [2:0]           npulse;
   logic                 m_end;
   logic                 valid;
   logic [1:0]           dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   logic seg_lvl[$];
   int   seg_len[$];

   timer_counter #(.WID(WID), .NSLOT(NSLOT), .END_GAP(END_GAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .value     (value),
      .npulse    (npulse),
      .m_end     (m_end),
      .valid     (valid),
      .dbg_state (dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic seg(input logic lvl, input int n);
      sig_in = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sig_in = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_all(input string tag, input int e_slot[NSLOT], input int e_np,
                            input logic e_end, input logic e_valid, input logic [1:0] e_st);
      for (int i = 0; i < NSLOT; i++)
         check($sformatf("%s slot%0d", tag, i), 64'(value[WID*i +: WID]), 64'(e_slot[i]));
      check({tag, " npulse"}, 64'(npulse), 64'(e_np));
      check({tag, " m_end"}, 64'(m_end), 64'(e_end));
      check({tag, " valid"}, 64'(valid), 64'(e_valid));
      check({tag, " state"}, 64'(dbg_state), 64'(e_st));
   endtask

   // Drive the queued segments, then score against the message-level rules:
   // pulses are counted until the first post-pulse low longer than END_GAP.
   task automatic play_and_score(input string tag);
      int   pulses[$];
      bit   ended;
      int   e_slot[NSLOT];
      int   e_np;
      logic e_valid;
      ended = 0;
      for (int s = 0; s < seg_lvl.size(); s++) begin
         seg(seg_lvl[s], seg_len[s]);
         if (seg_lvl[s]) begin
            if (!ended) pulses.push_back(seg_len[s]);
         end else if (pulses.size() > 0 && seg_len[s] > END_GAP) begin
            ended = 1;
         end
      end
      e_np = (pulses.size() > NSLOT + 1) ? NSLOT + 1 : pulses.size();
      for (int i = 0; i < NSLOT; i++) e_slot[i] = (i < pulses.size()) ? pulses[i] : 0;
      e_valid = ended && e_np >= 1 && e_np <= NSLOT;
      check_all(tag, e_slot, e_np, ended, e_valid, ended ? 2'd3 : 2'd2);
   endtask

   initial begin
      int z[NSLOT];
      int e[NSLOT];
      int k;
      for (int i = 0; i < NSLOT; i++) z[i] = 0;

      // Reset state and idle low line.
      do_reset();
      check_all("reset", z, 0, 1'b0, 1'b0, 2'd0);
      seg(1'b0, 50);
      check_all("idle50", z, 0, 1'b0, 1'b0, 2'd0);

      // Single 3-cycle pulse; end flag exactly 31 low cycles after the fall.
      seg(1'b1, 3);
      seg(1'b0, 31);
      check("single m_end_early", 64'(m_end), 64'd0);
      seg(1'b0, 1);
      check("single m_end_on_time", 64'(m_end), 64'd1);
      seg(1'b0, 8);
      e = '{3, 0, 0, 0, 0};
      check_all("single", e, 1, 1'b1, 1'b1, 2'd3);

      // DONE ignores input.
      seg(1'b1, 4);
      seg(1'b0, 5);
      check_all("done_frozen", e, 1, 1'b1, 1'b1, 2'd3);

      // Reset while in DONE.
      reset = 1'b1;
      seg(1'b0, 1);
      reset = 1'b0;
      check_all("reset_done", z, 0, 1'b0, 1'b0, 2'd0);

      // Three pulses 3/9/3.
      seg(1'b0, 3); seg(1'b1, 3); seg(1'b0, 10); seg(1'b1, 9);
      seg(1'b0, 10); seg(1'b1, 3); seg(1'b0, 40);
      e = '{3, 9, 3, 0, 0};
      check_all("three", e, 3, 1'b1, 1'b1, 2'd3);

      // Gap of exactly END_GAP keeps the message open.
      do_reset();
      seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 30); seg(1'b1, 4); seg(1'b0, 40);
      e = '{3, 4, 0, 0, 0};
      check_all("gap30", e, 2, 1'b1, 1'b1, 2'd3);

      // Gap of END_GAP+1 ends it; the following pulse is ignored.
      do_reset();
      seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 31); seg(1'b1, 4); seg(1'b0, 40);
      e = '{3, 0, 0, 0, 0};
      check_all("gap31", e, 1, 1'b1, 1'b1, 2'd3);

      // Overflow: six pulses, five stored, valid low.
      do_reset();
      seg(1'b0, 2);
      for (int p = 0; p < 6; p++) begin
         seg(1'b1, 2);
         seg(1'b0, (p == 5) ? 40 : 5);
      end
      e = '{2, 2, 2, 2, 2};
      check_all("overflow", e, 6, 1'b1, 1'b0, 2'd3);

      // Reset mid-pulse, then a fresh 4-cycle pulse.
      do_reset();
      seg(1'b0, 2);
      seg(1'b1, 5);
      reset = 1'b1;
      seg(1'b1, 1);
      reset = 1'b0;
      check_all("reset_mid", z, 0, 1'b0, 1'b0, 2'd0);
      seg(1'b0, 3); seg(1'b1, 4); seg(1'b0, 40);
      e = '{4, 0, 0, 0, 0};
      check_all("after_reset", e, 1, 1'b1, 1'b1, 2'd3);

      // Random pulse trains.
      for (int it = 0; it < 20; it++) begin
         do_reset();
         seg_lvl.delete();
         seg_len.delete();
         seg_lvl.push_back(1'b0);
         seg_len.push_back($urandom_range(1, 5));
         k = $urandom_range(1, 7);
         for (int j = 0; j < k; j++) begin
            seg_lvl.push_back(1'b1);
            seg_len.push_back($urandom_range(1, 10));
            seg_lvl.push_back(1'b0);
            if (j == k - 1)
               seg_len.push_back(40);
            else if ($urandom_range(0, 3) == 0)
               seg_len.push_back($urandom_range(28, 34));
            else
               seg_len.push_back($urandom_range(1, 12));
         end
         play_and_score($sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
